// File: rtl/alu_result_fifo.sv
// alu_result_fifo: capture stage behind the add/sub ALU.
// Each accepted ALU result is stored with its derived zero and carry flags in a DEPTH-entry
// circular buffer. The buffer drains over a valid/ready stream.
// Ports:
//   clk, rst_n                 clock and asynchronous active-low reset
//   in_valid / in_ready        upstream handshake (in_ready = not full)
//   alu_out, alu_carry,        ALU result, carry and op select, sampled on push
//   alu_sub
//   out_valid / out_ready      downstream handshake for the head entry
//   out_data, out_carry,       head entry fields; while empty they hold the last popped entry
//   out_zero, out_sub
//   count                      entries currently held
//   total_cnt                  accepted pushes, wraps modulo 2^16
module alu_result_fifo #(
  parameter int unsigned BITS  = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [BITS-1:0]            alu_out,
  input  logic                       alu_carry,
  input  logic                       alu_sub,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [BITS-1:0]            out_data,
  output logic                       out_carry,
  output logic                       out_zero,
  output logic                       out_sub,
  output logic [$clog2(DEPTH):0]     count,
  output logic [15:0]                total_cnt
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [BITS-1:0] data_mem  [DEPTH];
  logic            carry_mem [DEPTH];
  logic            zero_mem  [DEPTH];
  logic            sub_mem   [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [15:0]     total_q, total_d;

  // Fields of the most recently popped entry, shown while the buffer is empty.
  logic [BITS-1:0] last_data_q;
  logic            last_carry_q, last_zero_q, last_sub_q;

  logic push, pop;
  logic entry_carry, entry_zero;

  assign in_ready  = (count_q != CntW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Carry out of a subtract is meaningless to the consumer, so it is stored as 0.
  assign entry_carry = alu_sub ? 1'b0 : alu_carry;
  assign entry_zero  = (alu_out == '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    total_d  = total_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      total_d  = total_q + 16'd1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      total_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      total_q  <= total_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i]  <= '0;
        carry_mem[i] <= 1'b0;
        zero_mem[i]  <= 1'b0;
        sub_mem[i]   <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (wr_ptr_q == PtrW'(i))) begin
          data_mem[i]  <= alu_out;
          carry_mem[i] <= entry_carry;
          zero_mem[i]  <= entry_zero;
          sub_mem[i]   <= alu_sub;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_data_q  <= '0;
      last_carry_q <= 1'b0;
      last_zero_q  <= 1'b0;
      last_sub_q   <= 1'b0;
    end else if (pop) begin
      last_data_q  <= data_mem[rd_ptr_q];
      last_carry_q <= carry_mem[rd_ptr_q];
      last_zero_q  <= zero_mem[rd_ptr_q];
      last_sub_q   <= sub_mem[rd_ptr_q];
    end
  end

  always_comb begin
    out_data  = last_data_q;
    out_carry = last_carry_q;
    out_zero  = last_zero_q;
    out_sub   = last_sub_q;
    if (out_valid) begin
      out_data  = data_mem[rd_ptr_q];
      out_carry = carry_mem[rd_ptr_q];
      out_zero  = zero_mem[rd_ptr_q];
      out_sub   = sub_mem[rd_ptr_q];
    end
  end

  assign count     = count_q;
  assign total_cnt = total_q;

endmodule

// File: tb/tb_alu_result_fifo.sv
module tb_alu_result_fifo;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] alu_out = '0;
  logic       alu_carry = 1'b0;
  logic       alu_sub = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_carry;
  logic       out_zero;
  logic       out_sub;
  logic [2:0] count;
  logic [15:0] total_cnt;

  alu_result_fifo #(.BITS(8), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_out   (alu_out),
    .alu_carry (alu_carry),
    .alu_sub   (alu_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .out_zero  (out_zero),
    .out_sub   (out_sub),
    .count     (count),
    .total_cnt (total_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       carry;
    logic       zero;
    logic       sub;
  } entry_t;

  entry_t q[$];
  entry_t last;
  int     total_pushes;
  int     n_pass = 0;
  int     n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Compare every DUT output against the queue model.
  task automatic check_outputs();
    entry_t h;
    h = (q.size() > 0) ? q[0] : last;
    chk("out_valid", int'(out_valid), int'(q.size() > 0));
    chk("in_ready", int'(in_ready), int'(q.size() < DEPTH));
    chk("count", int'(count), q.size());
    chk("total_cnt", int'(total_cnt), total_pushes % 65536);
    chk("out_data", int'(out_data), int'(h.data));
    chk("out_carry", int'(out_carry), int'(h.carry));
    chk("out_zero", int'(out_zero), int'(h.zero));
    chk("out_sub", int'(out_sub), int'(h.sub));
  endtask

  // Called at a falling edge: check, drive, advance the model across the next rising edge.
  task automatic step(input logic iv, input logic [7:0] ao, input logic ac, input logic as_,
                      input logic ordy);
    bit do_push, do_pop;
    entry_t e;
    check_outputs();
    in_valid  = iv;
    alu_out   = ao;
    alu_carry = ac;
    alu_sub   = as_;
    out_ready = ordy;
    do_push = iv && (q.size() < DEPTH);
    do_pop  = ordy && (q.size() > 0);
    if (do_pop) last = q.pop_front();
    if (do_push) begin
      e.data  = ao;
      e.sub   = as_;
      e.zero  = (ao == 8'd0);
      e.carry = as_ ? 1'b0 : ac;
      q.push_back(e);
      total_pushes++;
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    q.delete();
    last = '0;
    total_pushes = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs();

    // Reset in the middle of a stream holding three entries.
    for (int i = 0; i < 3; i++) step(1'b1, 8'(i + 1), 1'b1, 1'b0, 1'b0);
    chk("pre_reset_count", int'(count), 3);
    #2 rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_total", int'(total_cnt), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs();

    // Add result with carry, then subtract result of zero with a stray carry.
    step(1'b1, 8'h10, 1'b1, 1'b0, 1'b0);
    chk("add_valid", int'(out_valid), 1);
    chk("add_data", int'(out_data), 8'h10);
    chk("add_carry", int'(out_carry), 1);
    chk("add_zero", int'(out_zero), 0);
    chk("add_sub", int'(out_sub), 0);
    step(1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
    step(1'b0, 8'h55, 1'b1, 1'b0, 1'b1);
    chk("sub_data", int'(out_data), 8'h00);
    chk("sub_zero", int'(out_zero), 1);
    chk("sub_carry", int'(out_carry), 0);
    chk("sub_sub", int'(out_sub), 1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("empty_valid", int'(out_valid), 0);
    chk("empty_hold_zero", int'(out_zero), 1);

    // Fill to full with the consumer stalled; the fifth value must be held off.
    for (int i = 0; i < 4; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0);
    chk("full_count", int'(count), 4);
    chk("full_in_ready", int'(in_ready), 0);
    step(1'b1, 8'hA4, 1'b0, 1'b0, 1'b0);
    chk("held_count", int'(count), 4);
    chk("held_head", int'(out_data), 8'hA0);
    step(1'b1, 8'hA4, 1'b0, 1'b0, 1'b1);
    chk("pop_when_full", int'(count), 3);
    step(1'b1, 8'hA4, 1'b0, 1'b0, 1'b0);
    chk("fifth_accepted", int'(count), 4);

    // Full, with both sides active for eight cycles; pointers wrap.
    for (int i = 0; i < 8; i++) step(1'b1, 8'hB0 + 8'(i), 1'b1, 1'b0, 1'b1);
    step(1'b1, 8'hC0, 1'b0, 1'b0, 1'b0);
    chk("wrap_count", int'(count), 4);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 3) == 0 ? 0 : $urandom),
           1'($urandom), 1'($urandom), ($urandom_range(0, 2) != 0));
    end

    // total_cnt wraps after 65536 pushes.
    do_reset();
    for (int i = 0; i < 70000 && total_pushes < 65537; i++) begin
      step(1'b1, 8'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    end
    chk("push_budget", total_pushes, 65537);
    chk("total_wrap", int'(total_cnt), 16'h0001);
    check_outputs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
